seq_detector_param: RTL and testbench
=====================================

Name: seq_detector_param

Overview:
Parametrised, runtime-programmable serial pattern detector. It is the Moore successor to the fixed "1100" detector. The block compares a 1-bit input stream against a PAT_LEN-bit pattern, MSB first, and asserts data_out while the FSM sits in its "full match" state. Pattern, overlap mode and an optional match counter make it reusable across the serial front ends in the design.

Parameters:
PAT_LEN, 4, pattern length in bits; legal range 2..16
PATTERN, 4'b1100, reset and default pattern, PAT_LEN bits; bit PAT_LEN-1 is the first bit expected
OVERLAP, 1, 1 = overlapping matches allowed; 0 = search restarts from empty after each match
CNT_W, 8, width of match_count

Ports:
clock  input  1  single clock; all state updates on posedge
reset  input  1  synchronous, active-high reset
data_valid  input  1  data_in is sampled only when high
data_in  input  1  serial input bit
pattern_load  input  1  load pattern_in into the pattern register
pattern_in  input  PAT_LEN  new pattern, MSB = first bit
data_out  output  1  Moore match flag (progress == PAT_LEN)
progress  output  $clog2(PAT_LEN+1)  number of pattern bits currently matched
match_count  output  CNT_W  saturating match counter (present only with SEQ_DET_COUNT_EN)

Behaviour:
- Reset (sampled at posedge clock, overrides everything): pattern_reg <= PATTERN, progress <= 0, match_count <= 0. data_out is 0 from the cycle after reset is sampled.
- State = progress, range 0..PAT_LEN. State 0 means nothing matched and state PAT_LEN means full match. data_out = (progress == PAT_LEN) and is decoded purely from the state, so it is Moore.
- Latency: data_out rises in the cycle after the clock edge that samples the final pattern bit, one cycle after that bit is presented.
- Transition on a valid bit b:
  - Let p = progress. If OVERLAP==0 and p==PAT_LEN, use p = 0.
  - next progress = the largest k <= min(p+1, PAT_LEN) such that the last k bits of (pattern_reg prefix of length p, then b) equal the pattern_reg prefix of length k. This is a KMP-style fallback.
  - If no such k exists, next progress = 0.
- data_valid low: progress, data_out and match_count hold. A held full-match state keeps data_out = 1.
- pattern_load high (reset low): pattern_reg <= pattern_in and progress <= 0. match_count is retained.
  - If pattern_load and data_valid are high together, the load wins and that data bit is discarded.
- All arithmetic is unsigned. progress never exceeds PAT_LEN.
- Out-of-range encodings are unreachable; if one occurs, next progress = 0.
- Reset mid-match discards the partial match; no match is reported for bits straddling the reset.

Optional Feature:
SEQ_DET_COUNT_EN
- Defined: the match_count port and a CNT_W-bit counter exist.
  - The counter increments by 1 on every clock edge where progress transitions into PAT_LEN.
  - Consecutive overlapping matches each count once.
  - It saturates at 2^CNT_W-1 with no wrap.
  - Cleared only by reset.
- Undefined: no counter is present and the match_count port is absent. All other behaviour is identical.

Decomposition:
- Package seq_det_pkg holds:
  - default PAT_LEN, PATTERN, CNT_W constants
  - progress width localparam expression
  - typedef for the progress state
- One combinational sub-module, seq_det_next_state.
  - Inputs: pattern_reg, progress, bit, OVERLAP parameter.
  - Output: next progress.
  - It contains the prefix/suffix compare loop.
- The top level holds pattern_reg, the progress register, the optional counter and the data_out decode.

Test Plan:
- Default pattern 1100, valid stream 1,1,0,0 -> progress 1,2,3,4. data_out=1 only in the cycle after the 4th bit. Then bit 1 -> progress 1, data_out 0.
- Stream 1,1,1,0,0 with pattern 1100 -> progress 1,2,2,3,4. The third 1 falls back to 2, not 0, and one match is reported.
- Pattern 1010, stream 1,0,1,0,1,0:
  - OVERLAP=1 -> data_out high after bits 4 and 6, match_count=2.
  - OVERLAP=0 -> high after bit 4 only, match_count=1.
- With progress=3, assert pattern_load with pattern_in=0110 and data_valid=1 simultaneously -> progress=0, bit discarded. Stream 0,1,1,0 -> match, match_count increments.
- data_valid low for 5 cycles mid-pattern (progress=2) -> progress holds at 2. Resuming 0,0 completes 1100, with data_out high for the full stall if stalled in the match state.
- CNT_W=2, five separate 1100 matches -> match_count 1,2,3,3,3. Then reset mid-pattern (progress=3) -> progress 0, match_count 0, data_out 0 next cycle.

Source files
------------

// File: rtl/seq_det_pkg.sv
// -----------------------------------------------------------------------------
// seq_det_pkg
// Shared constants and types for the parametrised serial pattern detector.
//   DEF_PAT_LEN / DEF_PATTERN / DEF_CNT_W : default configuration
//   prog_w()                              : width of the progress state
//   progress_t                            : progress state type at default size
// -----------------------------------------------------------------------------
package seq_det_pkg;

    localparam int         DEF_PAT_LEN = 4;
    localparam logic [3:0] DEF_PATTERN = 4'b1100;
    localparam int         DEF_CNT_W   = 8;

    // Progress counts 0..PAT_LEN inclusive, so it needs room for PAT_LEN+1 values.
    function automatic int prog_w(input int pat_len);
        return $clog2(pat_len + 1);
    endfunction

    localparam int DEF_PROG_W = $clog2(DEF_PAT_LEN + 1);

    typedef logic [DEF_PROG_W-1:0] progress_t;

endpackage

// File: rtl/seq_det_next_state.sv
// -----------------------------------------------------------------------------
// seq_det_next_state
// Combinational next-state function of the detector: given the currently
// matched prefix length and one new bit, returns the longest pattern prefix
// that is also a suffix of (matched prefix, new bit).
// Ports:
//   pattern       : PAT_LEN-bit pattern, MSB is the first bit expected
//   progress      : currently matched prefix length (0..PAT_LEN)
//   din           : incoming serial bit
//   next_progress : matched prefix length after consuming din
// -----------------------------------------------------------------------------
module seq_det_next_state
    import seq_det_pkg::*;
#(
    parameter int PAT_LEN = DEF_PAT_LEN,
    parameter int OVERLAP = 1,
    parameter int PW      = prog_w(PAT_LEN)
) (
    input  logic [PAT_LEN-1:0] pattern,
    input  logic [PW-1:0]      progress,
    input  logic               din,
    output logic [PW-1:0]      next_progress
);

    logic [PAT_LEN-1:0] pat_fwd;   // pattern in arrival order: pat_fwd[0] is first bit
    logic [PAT_LEN:0]   seq;       // matched prefix followed by din, arrival order
    logic [PW-1:0]      idx;
    logic [PW-1:0]      nxt;
    logic               ok;
    int                 pi;

    always_comb begin
        nxt = '0;
        idx = '0;
        ok  = 1'b0;
        for (int i = 0; i < PAT_LEN; i++) begin
            pat_fwd[i] = pattern[PAT_LEN-1-i];
        end

        pi = int'(progress);
        // Non-overlapping mode restarts the search from empty after a match.
        if (OVERLAP == 0 && pi == PAT_LEN) begin
            pi = 0;
        end

        seq = '0;
        for (int i = 0; i < PAT_LEN; i++) begin
            if (i < pi) begin
                seq[i] = pat_fwd[i];
            end else if (i == pi) begin
                seq[i] = din;
            end
        end
        if (pi == PAT_LEN) begin
            seq[PAT_LEN] = din;
        end

        // Out-of-range progress encodings fall through with nxt = 0.
        if (pi <= PAT_LEN) begin
            // Ascending k, so the last hit is the longest prefix/suffix overlap.
            for (int k = 1; k <= PAT_LEN; k++) begin
                ok = (k <= pi + 1);
                for (int j = 0; j < PAT_LEN; j++) begin
                    if (ok && j < k) begin
                        idx = PW'(pi + 1 - k + j);
                        if (seq[idx] != pat_fwd[j]) begin
                            ok = 1'b0;
                        end
                    end
                end
                if (ok) begin
                    nxt = PW'(k);
                end
            end
        end

        next_progress = nxt;
    end

endmodule

// File: rtl/seq_detector_param.sv
// -----------------------------------------------------------------------------
// seq_detector_param
// Runtime-programmable Moore serial pattern detector. Compares a 1-bit stream
// (MSB of the pattern first) against a PAT_LEN-bit pattern and raises data_out
// while the full-match state is held.
// Ports:
//   clock        : single clock, all state on posedge
//   reset        : synchronous active-high reset
//   data_valid   : data_in is consumed only when high
//   data_in      : serial input bit
//   pattern_load : load pattern_in (wins over data_valid, clears progress)
//   pattern_in   : new pattern, MSB = first bit
//   data_out     : high while progress == PAT_LEN
//   progress     : number of pattern bits currently matched
//   match_count  : saturating match counter, only when SEQ_DET_COUNT_EN is defined
// Build option: define SEQ_DET_COUNT_EN to add the match counter and its port.
// -----------------------------------------------------------------------------
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int                 PAT_LEN = DEF_PAT_LEN,
    parameter logic [PAT_LEN-1:0] PATTERN = PAT_LEN'(DEF_PATTERN),
    parameter int                 OVERLAP = 1,
    parameter int                 CNT_W   = DEF_CNT_W,
    localparam int                PW      = prog_w(PAT_LEN)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               data_valid,
    input  logic               data_in,
    input  logic               pattern_load,
    input  logic [PAT_LEN-1:0] pattern_in,
    output logic               data_out,
    output logic [PW-1:0]      progress
`ifdef SEQ_DET_COUNT_EN
    ,
    output logic [CNT_W-1:0]   match_count
`endif
);

    localparam logic [PW-1:0] FULL = PW'(PAT_LEN);

    logic [PAT_LEN-1:0] pattern_reg;
    logic [PW-1:0]      next_progress;

    seq_det_next_state #(
        .PAT_LEN (PAT_LEN),
        .OVERLAP (OVERLAP),
        .PW      (PW)
    ) u_next (
        .pattern       (pattern_reg),
        .progress      (progress),
        .din           (data_in),
        .next_progress (next_progress)
    );

    // data_out is registered alongside progress from the same next-state value,
    // so it always equals (progress == PAT_LEN) and stays a pure state decode.
    always_ff @(posedge clock) begin
        if (reset) begin
            pattern_reg <= PATTERN;
            progress    <= '0;
            data_out    <= 1'b0;
`ifdef SEQ_DET_COUNT_EN
            match_count <= '0;
`endif
        end else if (pattern_load) begin
            // A concurrent valid bit is dropped; the counter is kept.
            pattern_reg <= pattern_in;
            progress    <= '0;
            data_out    <= 1'b0;
        end else if (data_valid) begin
            progress <= next_progress;
            data_out <= (next_progress == FULL);
`ifdef SEQ_DET_COUNT_EN
            // Every entry into the full state counts, including FULL -> FULL
            // re-matches in overlap mode; the counter sticks at all-ones.
            if (next_progress == FULL && match_count != '1) begin
                match_count <= match_count + 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_seq_detector_param.sv
// -----------------------------------------------------------------------------
// tb_seq_detector_param
// Directed bench for seq_detector_param. Three instances share one stimulus:
//   dut_a : OVERLAP=1, CNT_W=8 (primary, scoreboarded every cycle)
//   dut_b : OVERLAP=0
//   dut_c : CNT_W=2 (counter saturation)
// -----------------------------------------------------------------------------
module tb_seq_detector_param;

    localparam int PL = 4;
    localparam int PW = $clog2(PL + 1);

    logic          clock = 1'b0;
    logic          reset;
    logic          data_valid;
    logic          data_in;
    logic          pattern_load;
    logic [PL-1:0] pattern_in;

    logic [PW-1:0] prog_a, prog_b, prog_c;
    logic          out_a, out_b, out_c;
`ifdef SEQ_DET_COUNT_EN
    logic [7:0]    cnt_a, cnt_b;
    logic [1:0]    cnt_c;
`endif

    always #5 clock = ~clock;

    seq_detector_param #(.PAT_LEN(PL), .PATTERN(4'b1100), .OVERLAP(1), .CNT_W(8)) dut_a (
        .clock(clock), .reset(reset), .data_valid(data_valid), .data_in(data_in),
        .pattern_load(pattern_load), .pattern_in(pattern_in),
        .data_out(out_a), .progress(prog_a)
`ifdef SEQ_DET_COUNT_EN
        , .match_count(cnt_a)
`endif
    );

    seq_detector_param #(.PAT_LEN(PL), .PATTERN(4'b1100), .OVERLAP(0), .CNT_W(8)) dut_b (
        .clock(clock), .reset(reset), .data_valid(data_valid), .data_in(data_in),
        .pattern_load(pattern_load), .pattern_in(pattern_in),
        .data_out(out_b), .progress(prog_b)
`ifdef SEQ_DET_COUNT_EN
        , .match_count(cnt_b)
`endif
    );

    seq_detector_param #(.PAT_LEN(PL), .PATTERN(4'b1100), .OVERLAP(1), .CNT_W(2)) dut_c (
        .clock(clock), .reset(reset), .data_valid(data_valid), .data_in(data_in),
        .pattern_load(pattern_load), .pattern_in(pattern_in),
        .data_out(out_c), .progress(prog_c)
`ifdef SEQ_DET_COUNT_EN
        , .match_count(cnt_c)
`endif
    );

    typedef struct {
        string         tag;
        logic [PW-1:0] prog;
        logic          out;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    // Drive one cycle of stimulus, queue the expected primary-DUT state, then
    // pop and compare once the edge has been taken.
    task automatic step(input logic v, input logic d, input logic ld, input logic rs,
                        input logic [PL-1:0] pin, input string tag,
                        input logic [PW-1:0] ep, input logic eo);
        exp_t e;
        reset        = rs;
        data_valid   = v;
        data_in      = d;
        pattern_load = ld;
        pattern_in   = pin;
        e.tag  = tag;
        e.prog = ep;
        e.out  = eo;
        sb.push_back(e);
        @(posedge clock);
        #1;
        if (sb.size() == 0) begin
            failures++;
            $error("FAIL %s scoreboard empty", tag);
        end else begin
            e = sb.pop_front();
            checks++;
            assert (prog_a === e.prog) else begin
                failures++;
                $error("FAIL %s progress observed=%0d expected=%0d", e.tag, prog_a, e.prog);
            end
            checks++;
            assert (out_a === e.out) else begin
                failures++;
                $error("FAIL %s data_out observed=%0b expected=%0b", e.tag, out_a, e.out);
            end
        end
    endtask

    task automatic bit_in(input logic d, input string tag, input logic [PW-1:0] ep, input logic eo);
        step(1'b1, d, 1'b0, 1'b0, '0, tag, ep, eo);
    endtask

    task automatic idle(input string tag, input logic [PW-1:0] ep, input logic eo);
        step(1'b0, 1'b0, 1'b0, 1'b0, '0, tag, ep, eo);
    endtask

    task automatic chk_b(input string tag, input logic [PW-1:0] ep, input logic eo);
        checks++;
        assert (prog_b === ep && out_b === eo) else begin
            failures++;
            $error("FAIL %s nonoverlap observed=%0d/%0b expected=%0d/%0b", tag, prog_b, out_b, ep, eo);
        end
    endtask

    task automatic chk_cnt(input string tag, input logic [7:0] obs, input logic [7:0] ex);
        checks++;
        assert (obs === ex) else begin
            failures++;
            $error("FAIL %s match_count observed=%0d expected=%0d", tag, obs, ex);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset
        step(1'b1, 1'b1, 1'b0, 1'b1, '0, "rst0", 3'd0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 4'b1111, "rst1", 3'd0, 1'b0);
`ifdef SEQ_DET_COUNT_EN
        chk_cnt("rst_cnt_a", cnt_a, 8'd0);
        chk_cnt("rst_cnt_c", {6'd0, cnt_c}, 8'd0);
`endif

        // Basic 1100 match, then a fresh 1 drops back to 1
        bit_in(1'b1, "b1100_1", 3'd1, 1'b0);
        bit_in(1'b1, "b1100_2", 3'd2, 1'b0);
        bit_in(1'b0, "b1100_3", 3'd3, 1'b0);
        bit_in(1'b0, "b1100_4", 3'd4, 1'b1);
        chk_b("b1100_4_b", 3'd4, 1'b1);
`ifdef SEQ_DET_COUNT_EN
        chk_cnt("m1_cnt_c", {6'd0, cnt_c}, 8'd1);
`endif
        bit_in(1'b1, "b1100_5", 3'd1, 1'b0);

        // 11100: third 1 falls back to 2
        bit_in(1'b0, "fb_clr", 3'd0, 1'b0);
        bit_in(1'b1, "fb_1", 3'd1, 1'b0);
        bit_in(1'b1, "fb_2", 3'd2, 1'b0);
        bit_in(1'b1, "fb_3", 3'd2, 1'b0);
        bit_in(1'b0, "fb_4", 3'd3, 1'b0);
        bit_in(1'b0, "fb_5", 3'd4, 1'b1);
`ifdef SEQ_DET_COUNT_EN
        chk_cnt("m2_cnt_a", cnt_a, 8'd2);
        chk_cnt("m2_cnt_c", {6'd0, cnt_c}, 8'd2);
`endif

        // Stall mid-pattern, then stall in the match state
        bit_in(1'b0, "st_clr", 3'd0, 1'b0);
        bit_in(1'b1, "st_1", 3'd1, 1'b0);
        bit_in(1'b1, "st_2", 3'd2, 1'b0);
        for (int i = 0; i < 5; i++) idle("st_hold2", 3'd2, 1'b0);
        bit_in(1'b0, "st_3", 3'd3, 1'b0);
        bit_in(1'b0, "st_4", 3'd4, 1'b1);
        for (int i = 0; i < 3; i++) idle("st_hold4", 3'd4, 1'b1);
`ifdef SEQ_DET_COUNT_EN
        chk_cnt("m3_cnt_c", {6'd0, cnt_c}, 8'd3);
`endif

        // Load collides with a valid bit; load wins and the bit is dropped
        bit_in(1'b0, "ld_clr", 3'd0, 1'b0);
        bit_in(1'b1, "ld_1", 3'd1, 1'b0);
        bit_in(1'b1, "ld_2", 3'd2, 1'b0);
        bit_in(1'b0, "ld_3", 3'd3, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 4'b0110, "ld_load", 3'd0, 1'b0);
        bit_in(1'b0, "ld_p1", 3'd1, 1'b0);
        bit_in(1'b1, "ld_p2", 3'd2, 1'b0);
        bit_in(1'b1, "ld_p3", 3'd3, 1'b0);
        bit_in(1'b0, "ld_p4", 3'd4, 1'b1);
`ifdef SEQ_DET_COUNT_EN
        chk_cnt("m4_cnt_a", cnt_a, 8'd4);
        chk_cnt("m4_sat_c", {6'd0, cnt_c}, 8'd3);
        chk_cnt("m4_cnt_b", cnt_b, 8'd4);
`endif

        // Pattern 1010: overlap vs non-overlap
        step(1'b0, 1'b0, 1'b1, 1'b0, 4'b1010, "ov_load", 3'd0, 1'b0);
        bit_in(1'b1, "ov_1", 3'd1, 1'b0);
        bit_in(1'b0, "ov_2", 3'd2, 1'b0);
        bit_in(1'b1, "ov_3", 3'd3, 1'b0);
        bit_in(1'b0, "ov_4", 3'd4, 1'b1);
        chk_b("ov_4_b", 3'd4, 1'b1);
        bit_in(1'b1, "ov_5", 3'd3, 1'b0);
        chk_b("ov_5_b", 3'd1, 1'b0);
        bit_in(1'b0, "ov_6", 3'd4, 1'b1);
        chk_b("ov_6_b", 3'd2, 1'b0);
`ifdef SEQ_DET_COUNT_EN
        chk_cnt("ov_cnt_a", cnt_a, 8'd6);
        chk_cnt("ov_cnt_b", cnt_b, 8'd5);
        chk_cnt("ov_sat_c", {6'd0, cnt_c}, 8'd3);
`endif

        // Reset mid-pattern discards the partial match and the counters
        step(1'b0, 1'b0, 1'b1, 1'b0, 4'b1100, "rm_load", 3'd0, 1'b0);
        bit_in(1'b1, "rm_1", 3'd1, 1'b0);
        bit_in(1'b1, "rm_2", 3'd2, 1'b0);
        bit_in(1'b0, "rm_3", 3'd3, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1, '0, "rm_rst", 3'd0, 1'b0);
        bit_in(1'b0, "rm_after", 3'd0, 1'b0);
`ifdef SEQ_DET_COUNT_EN
        chk_cnt("rm_cnt_a", cnt_a, 8'd0);
        chk_cnt("rm_cnt_c", {6'd0, cnt_c}, 8'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
